half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder.sv | 58 +++++
 tb/tb_half_adder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Half adder with combinational sum/carry, one-cycle registered copies,
// and a saturating counter of clock edges sampled with carry set.
module half_adder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             s,
    output logic             c,
    output logic             s_q,
    output logic             c_q,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_s_q;
    logic             r_c_q;
    logic [CNT_W-1:0] r_carry_cnt;
    logic             w_sum;
    logic             w_carry;
    logic             w_cnt_inc;

    assign w_sum     = a ^ b;
    assign w_carry   = a & b;
    assign w_cnt_inc = w_carry && (r_carry_cnt != CNT_MAX);

    // One-cycle registered copy of the combinational result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q <= 1'b0;
            r_c_q <= 1'b0;
        end else begin
            r_s_q <= w_sum;
            r_c_q <= w_carry;
        end
    end

    // Carry-event counter; holds at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_carry_cnt <= r_carry_cnt + CNT_W'(1);
        end
    end

    assign s         = w_sum;
    assign c         = w_carry;
    assign s_q       = r_s_q;
    assign c_q       = r_c_q;
    assign carry_cnt = r_carry_cnt;
    assign cnt_sat   = (r_carry_cnt == CNT_MAX);

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: directed stimulus pushes expectations,
// a monitor process pops and compares them against the live DUT outputs.
module tb_half_adder;

    typedef enum int {SIG_CS, SIG_Q, SIG_BOTH, SIG_CNT, SIG_SAT, SIG_CNT3, SIG_SAT3} sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [15:0] exp;
    } exp_t;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        s, c, s_q, c_q, cnt_sat;
    logic [15:0] carry_cnt;
    logic        s3, c3, s_q3, c_q3, cnt_sat3;
    logic [2:0]  carry_cnt3;

    exp_t        sb_q[$];
    event        ev_chk;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  sum_tbl [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic [1:0]  prev_sum;

    half_adder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s), .c(c),
        .s_q(s_q), .c_q(c_q), .carry_cnt(carry_cnt), .cnt_sat(cnt_sat)
    );

    half_adder #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s3), .c(c3),
        .s_q(s_q3), .c_q(c_q3), .carry_cnt(carry_cnt3), .cnt_sat(cnt_sat3)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
            else        clk = 1'b0;
        end
    end

    // Monitor: drain every pending expectation against the current outputs
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(ev_chk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.sig)
                    SIG_CS:   act = 16'({c, s});
                    SIG_Q:    act = 16'({c_q, s_q});
                    SIG_BOTH: act = 16'(s_q & c_q);
                    SIG_CNT:  act = carry_cnt;
                    SIG_SAT:  act = 16'(cnt_sat);
                    SIG_CNT3: act = 16'(carry_cnt3);
                    SIG_SAT3: act = 16'(cnt_sat3);
                    default:  act = 16'hxxxx;
                endcase
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0h, expected %0h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string nm, input sig_e sg, input logic [15:0] v);
        exp_t e;
        e.name = nm;
        e.sig  = sg;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic chk();
        #1;
        ->ev_chk;
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        clk_en = 1'b0;
        rst_n  = 1'b0;
        a      = 1'b0;
        b      = 1'b0;

        // Unclocked sweep under reset: combinational path only
        for (int t = 0; t < 10; t++) begin
            b = t[0];
            a = t[1];
            #50;
            push_exp("sweep_cs", SIG_CS, 16'(sum_tbl[{a, b}]));
            if (t == 0) begin
                push_exp("rst_q",    SIG_Q,    16'd0);
                push_exp("rst_cnt",  SIG_CNT,  16'd0);
                push_exp("rst_sat",  SIG_SAT,  16'd0);
                push_exp("rst_cnt3", SIG_CNT3, 16'd0);
                push_exp("rst_sat3", SIG_SAT3, 16'd0);
            end
            chk();
            #48;
        end
        push_exp("sweep_11", SIG_CS, 16'd2);
        a = 1'b1; b = 1'b1;
        chk();

        // Release reset with a=1,b=0: first edge loads 01
        clk_en = 1'b1;
        @(negedge clk);
        a = 1'b1; b = 1'b0;
        rst_n = 1'b1;
        push_exp("lat_before", SIG_Q, 16'd0);
        chk();
        @(negedge clk);
        push_exp("lat_after", SIG_Q,   16'd1);
        push_exp("lat_cnt",   SIG_CNT, 16'd0);
        chk();

        // Mid-cycle input change must not reach registered outputs yet
        a = 1'b1; b = 1'b1;
        push_exp("mid_cs", SIG_CS, 16'd2);
        push_exp("mid_q",  SIG_Q,  16'd1);
        chk();
        edges(3);
        push_exp("pre_rst_cnt", SIG_CNT, 16'd3);
        push_exp("pre_rst_q",   SIG_Q,   16'd2);
        chk();

        // Async reset between edges
        rst_n = 1'b0;
        push_exp("arst_cnt",  SIG_CNT,  16'd0);
        push_exp("arst_cnt3", SIG_CNT3, 16'd0);
        push_exp("arst_q",    SIG_Q,    16'd0);
        push_exp("arst_cs",   SIG_CS,   16'd2);
        chk();
        a = 1'b0;
        push_exp("arst_cs_track", SIG_CS, 16'd1);
        chk();

        // Counter: 5 carry edges then hold
        @(negedge clk);
        a = 1'b1; b = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        push_exp("cnt_first", SIG_CNT, 16'd1);
        chk();
        edges(4);
        push_exp("cnt5",  SIG_CNT,  16'd5);
        push_exp("cnt5_3", SIG_CNT3, 16'd5);
        chk();
        a = 1'b0;
        edges(3);
        push_exp("cnt_hold",  SIG_CNT,  16'd5);
        push_exp("cnt_hold3", SIG_CNT3, 16'd5);
        push_exp("sat3_lo",   SIG_SAT3, 16'd0);
        chk();

        // Saturation of the 3-bit counter over 10 carry edges
        a = 1'b1;
        edges(2);
        push_exp("sat_reach",  SIG_CNT3, 16'd7);
        push_exp("sat_flag",   SIG_SAT3, 16'd1);
        chk();
        edges(8);
        push_exp("sat_stay",   SIG_CNT3, 16'd7);
        push_exp("sat_flag2",  SIG_SAT3, 16'd1);
        push_exp("cnt15",      SIG_CNT,  16'd15);
        push_exp("sat16_lo",   SIG_SAT,  16'd0);
        chk();

        // Reset clears a saturated counter
        rst_n = 1'b0;
        push_exp("sat_rst_cnt3", SIG_CNT3, 16'd0);
        push_exp("sat_rst_flag", SIG_SAT3, 16'd0);
        chk();
        @(negedge clk);
        rst_n = 1'b1;

        // Random exhaustive: {c,s}=a+b now, registered = previous sum
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        push_exp("rnd_cs", SIG_CS, 16'(sum_tbl[{a, b}]));
        chk();
        prev_sum = sum_tbl[{a, b}];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            push_exp("rnd_q",    SIG_Q,    16'(prev_sum));
            push_exp("rnd_both", SIG_BOTH, 16'd0);
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            push_exp("rnd_cs", SIG_CS, 16'(sum_tbl[{a, b}]));
            chk();
            prev_sum = sum_tbl[{a, b}];
        end

        #10;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
